// File: rtl/axis_byte_packer_32.sv
// rtl/axis_byte_packer_32.sv - packs an 8-bit AXI-Stream into MSB-first 32-bit words with tkeep
// Optional per-packet statistics enabled by defining AXIS_PACK_STATS_EN.
`timescale 1ns/1ps
module axis_byte_packer_32 #(
    parameter logic [7:0] PAD_BYTE  = 8'h00,
    parameter int         LEN_WIDTH = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
`ifdef AXIS_PACK_STATS_EN
    ,
    output logic [31:0]          pkt_count,
    output logic [LEN_WIDTH-1:0] last_pkt_bytes
`endif
);

    if (LEN_WIDTH < 1) begin : g_len_check
        $error("LEN_WIDTH must be at least 1");
    end

    typedef enum logic {IDLE, FILL} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  lane;
    logic [23:0] acc;
    logic        accept;
    logic        complete;
    logic [31:0] word_next;
    logic [3:0]  keep_next;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (complete) begin
            state_next = IDLE;
        end else if (accept) begin
            state_next = FILL;
        end
    end

    always_comb begin
        s_axis_tready = !m_axis_tvalid || m_axis_tready;
        accept        = s_axis_tvalid && s_axis_tready;
        complete      = accept && ((lane == 2'd3) || s_axis_tlast);
    end

    // Earlier bytes of the word come from acc; unfilled lanes get PAD_BYTE.
    always_comb begin
        word_next = {s_axis_tdata, {3{PAD_BYTE}}};
        keep_next = 4'h8;
        case (lane)
            2'd1: begin
                word_next = {acc[23:16], s_axis_tdata, {2{PAD_BYTE}}};
                keep_next = 4'hC;
            end
            2'd2: begin
                word_next = {acc[23:8], s_axis_tdata, PAD_BYTE};
                keep_next = 4'hE;
            end
            2'd3: begin
                word_next = {acc, s_axis_tdata};
                keep_next = 4'hF;
            end
            default: begin
                word_next = {s_axis_tdata, {3{PAD_BYTE}}};
                keep_next = 4'h8;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lane          <= 2'd0;
            acc           <= 24'd0;
            m_axis_tdata  <= 32'd0;
            m_axis_tkeep  <= 4'd0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (accept && !complete) begin
                case (lane)
                    2'd0:    acc[23:16] <= s_axis_tdata;
                    2'd1:    acc[15:8]  <= s_axis_tdata;
                    default: acc[7:0]   <= s_axis_tdata;
                endcase
                lane <= lane + 2'd1;
            end
            if (complete) begin
                lane          <= 2'd0;
                m_axis_tdata  <= word_next;
                m_axis_tkeep  <= keep_next;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef AXIS_PACK_STATS_EN
    logic [LEN_WIDTH-1:0] byte_cnt;
    logic [LEN_WIDTH-1:0] byte_cnt_inc;

    assign byte_cnt_inc = (&byte_cnt) ? byte_cnt : byte_cnt + 1'b1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count      <= 32'd0;
            last_pkt_bytes <= '0;
            byte_cnt       <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (accept) begin
                if (s_axis_tlast) begin
                    last_pkt_bytes <= byte_cnt_inc;
                    byte_cnt       <= '0;
                end else begin
                    byte_cnt <= byte_cnt_inc;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_byte_packer_32.sv
// tb/tb_axis_byte_packer_32.sv - directed self-checking bench for axis_byte_packer_32
`timescale 1ns/1ps
module tb_axis_byte_packer_32;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready, s_tready_ff;
    logic [31:0] m_tdata, m_tdata_ff;
    logic [3:0]  m_tkeep, m_tkeep_ff;
    logic        m_tlast, m_tlast_ff;
    logic        m_tvalid, m_tvalid_ff;
    logic        m_tready;
`ifdef AXIS_PACK_STATS_EN
    logic [31:0] pkt_count, pkt_count_ff;
    logic [15:0] last_pkt_bytes, last_pkt_bytes_ff;
`endif

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axis_byte_packer_32 dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
`ifdef AXIS_PACK_STATS_EN
        , .pkt_count(pkt_count), .last_pkt_bytes(last_pkt_bytes)
`endif
    );

    axis_byte_packer_32 #(.PAD_BYTE(8'hFF)) dut_ff (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready_ff),
        .m_axis_tdata(m_tdata_ff), .m_axis_tkeep(m_tkeep_ff), .m_axis_tlast(m_tlast_ff),
        .m_axis_tvalid(m_tvalid_ff), .m_axis_tready(m_tready)
`ifdef AXIS_PACK_STATS_EN
        , .pkt_count(pkt_count_ff), .last_pkt_bytes(last_pkt_bytes_ff)
`endif
    );

    typedef struct {
        logic [7:0]  b;
        logic        l;
        logic        word;
        logic [31:0] data;
        logic [31:0] data_ff;
        logic [3:0]  keep;
        logic        last;
        logic [15:0] len;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        s_tdata  = b;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //           byte   last  word  data          data_ff       keep  last  len
        vecs[0]  = '{8'h11, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 16'd0};
        vecs[1]  = '{8'h22, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 16'd0};
        vecs[2]  = '{8'h33, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 16'd0};
        vecs[3]  = '{8'h44, 1'b1, 1'b1, 32'h11223344, 32'h11223344, 4'hF, 1'b1, 16'd4};
        vecs[4]  = '{8'hA5, 1'b1, 1'b1, 32'hA5000000, 32'hA5FFFFFF, 4'h8, 1'b1, 16'd1};
        vecs[5]  = '{8'h01, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 16'd0};
        vecs[6]  = '{8'h02, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 16'd0};
        vecs[7]  = '{8'h03, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 16'd0};
        vecs[8]  = '{8'h04, 1'b0, 1'b1, 32'h01020304, 32'h01020304, 4'hF, 1'b0, 16'd0};
        vecs[9]  = '{8'h05, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 16'd0};
        vecs[10] = '{8'h06, 1'b1, 1'b1, 32'h05060000, 32'h0506FFFF, 4'hC, 1'b1, 16'd6};

        aresetn  = 1'b0;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("reset_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("reset_tdata", m_tdata, 32'd0);
        chk("reset_tkeep", {28'd0, m_tkeep}, 32'd0);
        chk("reset_tlast", {31'd0, m_tlast}, 32'd0);
        chk("reset_s_tready", {31'd0, s_tready}, 32'd1);
`ifdef AXIS_PACK_STATS_EN
        chk("reset_pkt_count", pkt_count, 32'd0);
        chk("reset_last_pkt_bytes", {16'd0, last_pkt_bytes}, 32'd0);
`endif
        aresetn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            send(vecs[i].b, vecs[i].l);
            chk($sformatf("vec%0d_tvalid", i), {31'd0, m_tvalid}, {31'd0, vecs[i].word});
            if (vecs[i].word) begin
                chk($sformatf("vec%0d_tdata", i), m_tdata, vecs[i].data);
                chk($sformatf("vec%0d_tkeep", i), {28'd0, m_tkeep}, {28'd0, vecs[i].keep});
                chk($sformatf("vec%0d_tlast", i), {31'd0, m_tlast}, {31'd0, vecs[i].last});
                chk($sformatf("vec%0d_pad_ff", i), m_tdata_ff, vecs[i].data_ff);
            end
`ifdef AXIS_PACK_STATS_EN
            if (vecs[i].l) begin
                chk($sformatf("vec%0d_last_pkt_bytes", i), {16'd0, last_pkt_bytes}, {16'd0, vecs[i].len});
            end
`endif
        end
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        chk("drain_tvalid", {31'd0, m_tvalid}, 32'd0);
`ifdef AXIS_PACK_STATS_EN
        chk("pkt_count_3", pkt_count, 32'd3);
`endif

        // Back-pressure: stall the first word of a 6-byte packet for 10 cycles.
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        m_tready = 1'b0;
        send(8'h04, 1'b0);
        s_tdata = 8'h05;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp%0d_s_tready", c), {31'd0, s_tready}, 32'd0);
            chk($sformatf("bp%0d_tdata", c), m_tdata, 32'h01020304);
            chk($sformatf("bp%0d_tvalid", c), {31'd0, m_tvalid}, 32'd1);
            @(posedge aclk);
            #1;
        end
        m_tready = 1'b1;
        #1;
        chk("bp_release_s_tready", {31'd0, s_tready}, 32'd1);
        @(posedge aclk);
        #1;
        chk("bp_handoff_tvalid", {31'd0, m_tvalid}, 32'd0);
        send(8'h06, 1'b1);
        chk("bp_tail_tvalid", {31'd0, m_tvalid}, 32'd1);
        chk("bp_tail_tdata", m_tdata, 32'h05060000);
        chk("bp_tail_tkeep", {28'd0, m_tkeep}, 32'hC);
        chk("bp_tail_tlast", {31'd0, m_tlast}, 32'd1);
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;

        // Asynchronous reset with a partial word held.
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        s_tvalid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("midrst_tdata", m_tdata, 32'd0);
        chk("midrst_s_tready", {31'd0, s_tready}, 32'd1);
`ifdef AXIS_PACK_STATS_EN
        chk("midrst_pkt_count", pkt_count, 32'd0);
`endif
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        send(8'hDE, 1'b0);
        send(8'hAD, 1'b0);
        send(8'hBE, 1'b0);
        chk("postrst_no_early_word", {31'd0, m_tvalid}, 32'd0);
        send(8'hEF, 1'b1);
        chk("postrst_tvalid", {31'd0, m_tvalid}, 32'd1);
        chk("postrst_tdata", m_tdata, 32'hDEADBEEF);
        chk("postrst_tkeep", {28'd0, m_tkeep}, 32'hF);
        chk("postrst_tlast", {31'd0, m_tlast}, 32'd1);
`ifdef AXIS_PACK_STATS_EN
        chk("postrst_last_pkt_bytes", {16'd0, last_pkt_bytes}, 32'd4);
`endif
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
